// File: rtl/redirect_controller_if.sv
// Redirect bus between pipeline control and the fetch unit. The controller uses
// the slave modport; the pipeline/fetch side uses the master modport.
interface redirect_controller_if;
  logic        BranchTakenE;
  logic [31:0] PCTargetE;
  logic        trap;
  logic [31:0] TrapVector;
  logic        mret;
  logic [31:0] MEPC;
  logic        FetchReady;
  logic        RedirectValid;
  logic [31:0] RedirectPC;
  logic        FlushD;
  logic        FlushE;
  logic        StallF;
  logic [31:0] RedirectCount;

  modport master (
    output BranchTakenE, PCTargetE, trap, TrapVector, mret, MEPC, FetchReady,
    input  RedirectValid, RedirectPC, FlushD, FlushE, StallF, RedirectCount
  );

  modport slave (
    input  BranchTakenE, PCTargetE, trap, TrapVector, mret, MEPC, FetchReady,
    output RedirectValid, RedirectPC, FlushD, FlushE, StallF, RedirectCount
  );
endinterface

// File: rtl/redirect_controller.sv
// Redirect controller: arbitrates trap/mret/branch redirects, handshakes them to fetch,
// and flushes decode/execute. Optional redirect counter enabled by REDIRECT_STATS_EN.
module redirect_controller (
  input  logic                  CLK,
  input  logic                  RST,
  redirect_controller_if.slave  rdr
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    REDIRECT = 2'b01,
    DRAIN    = 2'b10
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic        valid_q;
  logic        flushd_q;
  logic        flushe_q;
  logic        event_d;
  logic [31:0] sel_pc_d;

  // Instruction addresses are word aligned; the low two bits are always dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Event detection and priority selection of the redirect target
  always_comb begin
    event_d  = rdr.trap | rdr.mret | rdr.BranchTakenE;
    sel_pc_d = rdr.PCTargetE;
    if (rdr.trap) begin
      sel_pc_d = rdr.TrapVector;
    end else if (rdr.mret) begin
      sel_pc_d = rdr.MEPC;
    end else begin
      sel_pc_d = rdr.PCTargetE;
    end
  end

  // Redirect FSM with registered Moore outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      pc_q     <= 32'h0000_0000;
      valid_q  <= 1'b0;
      flushd_q <= 1'b0;
      flushe_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DRAIN: begin
          if (event_d) begin
            state_q  <= REDIRECT;
            pc_q     <= align_pc(sel_pc_d);
            valid_q  <= 1'b1;
            flushd_q <= 1'b1;
            flushe_q <= 1'b1;
          end else begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            flushd_q <= 1'b0;
            flushe_q <= 1'b0;
          end
        end
        REDIRECT: begin
          // A trap always wins, even over a handshake completing this edge.
          if (rdr.trap) begin
            state_q  <= REDIRECT;
            pc_q     <= align_pc(rdr.TrapVector);
            valid_q  <= 1'b1;
            flushd_q <= 1'b1;
            flushe_q <= 1'b1;
          end else if (rdr.FetchReady) begin
            state_q  <= DRAIN;
            valid_q  <= 1'b0;
            flushd_q <= 1'b1;
            flushe_q <= 1'b0;
          end else begin
            state_q  <= REDIRECT;
            valid_q  <= 1'b1;
            flushd_q <= 1'b1;
            flushe_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          valid_q  <= 1'b0;
          flushd_q <= 1'b0;
          flushe_q <= 1'b0;
        end
      endcase
    end
  end

  assign rdr.RedirectValid = valid_q;
  assign rdr.RedirectPC    = pc_q;
  assign rdr.FlushD        = flushd_q;
  assign rdr.FlushE        = flushe_q;
  assign rdr.StallF        = valid_q & ~rdr.FetchReady;

`ifdef REDIRECT_STATS_EN
  logic [31:0] count_q;
  logic        handshake_d;

  assign handshake_d = valid_q & rdr.FetchReady;

  // Completed-handshake counter, wraps naturally at 32 bits
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= 32'h0000_0000;
    end else if (handshake_d) begin
      count_q <= count_q + 32'd1;
    end else begin
      count_q <= count_q;
    end
  end

  assign rdr.RedirectCount = count_q;
`else
  assign rdr.RedirectCount = 32'h0000_0000;
`endif

endmodule
